// File: rtl/riscv_pkg.sv
// Shared branch-resolution types: funct3 branch encodings and the ID/EX control slice.
package riscv_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic [2:0] funct3;
        logic       pred_taken;
    } ex_ctrl_t;

endpackage

// File: rtl/ex_branch_resolver_branch_cmp.sv
// Combinational branch condition evaluator; reserved funct3 codes resolve not-taken and flag illegal.
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     taken = (a == b);
            BNE:     taken = (a != b);
            BLT:     taken = ($signed(a) <  $signed(b));
            BGE:     taken = ($signed(a) >= $signed(b));
            BLTU:    taken = (a <  b);
            BGEU:    taken = (a >= b);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_branch_resolver.sv
// EX-stage branch/jump resolver: ID/EX control register, misprediction redirect, saturating perf counters.
module ex_branch_resolver
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic             Branch_d,
    input  logic             Jump_d,
    input  logic             JumpReg_d,
    input  logic [2:0]       funct3_d,
    input  logic             pred_taken_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [XLEN-1:0]  src_a_e,
    input  logic [XLEN-1:0]  src_b_e,
    output logic             redirect_e,
    output logic [XLEN-1:0]  redirect_pc_e,
    output logic             flush_fd,
    output logic             illegal_br_e,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    ex_ctrl_t         ctrl_q, ctrl_d;
    logic [XLEN-1:0]  pc_e_q, pc_e_d;
    logic [XLEN-1:0]  imm_e_q, imm_e_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             cond_taken;
    logic             cond_illegal;
    logic [XLEN-1:0]  taken_tgt;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  jalr_tgt;
    logic             leaving;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_branch_cmp (
        .funct3  (ctrl_q.funct3),
        .a       (src_a_e),
        .b       (src_b_e),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign taken_tgt = pc_e_q + imm_e_q;
    assign seq_pc    = pc_e_q + XLEN'(4);
    assign jalr_sum  = src_a_e + imm_e_q;
    assign jalr_tgt  = {jalr_sum[XLEN-1:1], 1'b0};

    // JumpReg outranks Jump, which outranks Branch, when decode sets several.
    always_comb begin
        redirect_e    = 1'b0;
        redirect_pc_e = '0;
        if (ctrl_q.valid) begin
            if (ctrl_q.jump_reg) begin
                redirect_e    = 1'b1;
                redirect_pc_e = jalr_tgt;
            end else if (ctrl_q.jump) begin
                if (!ctrl_q.pred_taken) begin
                    redirect_e    = 1'b1;
                    redirect_pc_e = taken_tgt;
                end
            end else if (ctrl_q.branch) begin
                if (cond_taken && !ctrl_q.pred_taken) begin
                    redirect_e    = 1'b1;
                    redirect_pc_e = taken_tgt;
                end else if (!cond_taken && ctrl_q.pred_taken) begin
                    redirect_e    = 1'b1;
                    redirect_pc_e = seq_pc;
                end
            end
        end
    end

    assign flush_fd     = redirect_e;
    assign illegal_br_e = ctrl_q.valid & ctrl_q.branch & cond_illegal;

    // A redirect squashes the wrong-path instruction currently in ID.
    always_comb begin
        ctrl_d  = ctrl_q;
        pc_e_d  = pc_e_q;
        imm_e_d = imm_e_q;
        if (!stall_e) begin
            if (flush_e || redirect_e) begin
                ctrl_d = '0;
            end else begin
                ctrl_d.valid      = valid_d;
                ctrl_d.branch     = Branch_d;
                ctrl_d.jump       = Jump_d;
                ctrl_d.jump_reg   = JumpReg_d;
                ctrl_d.funct3     = funct3_d;
                ctrl_d.pred_taken = pred_taken_d;
                pc_e_d            = pc_d;
                imm_e_d           = imm_d;
            end
        end
    end

    assign leaving = ctrl_q.valid & ~stall_e;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (leaving && ctrl_q.branch && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (leaving && redirect_e && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q        <= '0;
            pc_e_q        <= '0;
            imm_e_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            pc_e_q        <= pc_e_d;
            imm_e_q       <= imm_e_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_ex_branch_resolver.sv
// Directed plus random bench for ex_branch_resolver against an instruction-level reference model.
module tb_ex_branch_resolver;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, stall_e, flush_e, valid_d, Branch_d, Jump_d, JumpReg_d, pred_taken_d;
    logic [2:0]    funct3_d;
    logic [31:0]   pc_d, imm_d, src_a_e, src_b_e;
    logic          redirect_e, flush_fd, illegal_br_e;
    logic [31:0]   redirect_pc_e;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    int total = 0;
    int bad   = 0;

    // Model of the instruction sitting in EX
    bit        m_valid, m_br, m_j, m_jr, m_pred;
    bit [2:0]  m_f3;
    bit [31:0] m_pc, m_imm;
    int        m_bc, m_mc;

    ex_branch_resolver #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .Branch_d(Branch_d), .Jump_d(Jump_d), .JumpReg_d(JumpReg_d),
        .funct3_d(funct3_d), .pred_taken_d(pred_taken_d), .pc_d(pc_d), .imm_d(imm_d),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .redirect_e(redirect_e),
        .redirect_pc_e(redirect_pc_e), .flush_fd(flush_fd), .illegal_br_e(illegal_br_e),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
        int sa = int'(a);
        int sb = int'(b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_out(output bit r, output bit [31:0] rpc, output bit ill);
        bit t;
        r = 0; rpc = 0;
        t   = cond_true(m_f3, src_a_e, src_b_e);
        ill = m_valid && m_br && (m_f3 == 3'd2 || m_f3 == 3'd3);
        if (!m_valid) return;
        if (m_jr) begin
            r = 1; rpc = (src_a_e + m_imm) & ~32'd1;
        end else if (m_j) begin
            if (!m_pred) begin r = 1; rpc = m_pc + m_imm; end
        end else if (m_br) begin
            if (t && !m_pred) begin r = 1; rpc = m_pc + m_imm; end
            else if (!t && m_pred) begin r = 1; rpc = m_pc + 32'd4; end
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_br = 0; m_j = 0; m_jr = 0; m_pred = 0; m_f3 = 0;
        m_pc = 0; m_imm = 0; m_bc = 0; m_mc = 0;
    endtask

    // Called at a negedge with inputs set; checks outputs, then advances one clock.
    task automatic cycle();
        bit r, ill;
        bit [31:0] rpc;
        #1;
        model_out(r, rpc, ill);
        chk("redirect_e", {31'd0, redirect_e}, {31'd0, r});
        chk("redirect_pc_e", redirect_pc_e, rpc);
        chk("flush_fd", {31'd0, flush_fd}, {31'd0, r});
        chk("illegal_br_e", {31'd0, illegal_br_e}, {31'd0, ill});
        chk("branch_cnt", 32'(branch_cnt), 32'(m_bc));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mc));
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (!stall_e) begin
            if (m_valid) begin
                if (m_br && m_bc < CMAX) m_bc++;
                if (r && m_mc < CMAX) m_mc++;
            end
            if (flush_e || r) begin
                m_valid = 0; m_br = 0; m_j = 0; m_jr = 0; m_pred = 0; m_f3 = 0;
            end else begin
                m_valid = valid_d; m_br = Branch_d; m_j = Jump_d; m_jr = JumpReg_d;
                m_f3 = funct3_d; m_pred = pred_taken_d; m_pc = pc_d; m_imm = imm_d;
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input bit br, input bit j, input bit jr, input bit [2:0] f3,
                         input bit pred, input bit [31:0] pc, input bit [31:0] imm);
        valid_d = 1; Branch_d = br; Jump_d = j; JumpReg_d = jr;
        funct3_d = f3; pred_taken_d = pred; pc_d = pc; imm_d = imm;
    endtask

    task automatic idle();
        valid_d = 0; Branch_d = 0; Jump_d = 0; JumpReg_d = 0;
        funct3_d = 0; pred_taken_d = 0; pc_d = 0; imm_d = 0;
    endtask

    initial begin
        reset = 1; stall_e = 0; flush_e = 0; src_a_e = 0; src_b_e = 0;
        idle();
        model_clear();
        @(negedge clk);
        @(posedge clk); @(posedge clk);
        @(negedge clk);

        // Out of reset, idle
        reset = 0;
        cycle();
        chk("rst_bc", 32'(branch_cnt), 32'd0);

        // beq taken, predicted not-taken; a JALR waiting in ID must be squashed
        issue(1, 0, 0, 3'd0, 0, 32'h100, 32'h20);
        cycle();
        issue(0, 0, 1, 3'd0, 0, 32'h500, 32'h0);
        src_a_e = 5; src_b_e = 5;
        #1 chk("beq_pc", redirect_pc_e, 32'h120);
        cycle();
        idle();
        cycle();
        chk("beq_bc", 32'(branch_cnt), 32'd1);
        chk("beq_mc", 32'(mispred_cnt), 32'd1);

        // Backward blt, correctly predicted taken
        issue(1, 0, 0, 3'd4, 1, 32'h200, 32'hFFFF_FFF8);
        cycle();
        idle();
        src_a_e = 32'hFFFF_FFFF; src_b_e = 0;
        cycle();
        cycle();

        // bne mispredicted taken, stalled 3 cycles
        issue(1, 0, 0, 3'd1, 1, 32'h300, 32'h40);
        cycle();
        idle();
        src_a_e = 7; src_b_e = 7; stall_e = 1;
        repeat (3) cycle();
        stall_e = 0;
        #1 chk("bne_pc", redirect_pc_e, 32'h304);
        cycle();
        cycle();
        chk("bne_mc", 32'(mispred_cnt), 32'd2);

        // JALR bit-0 clearing, then JAL predicted taken
        issue(0, 0, 1, 3'd0, 0, 32'h400, 32'h4);
        cycle();
        idle();
        src_a_e = 32'h1003;
        #1 chk("jalr_pc", redirect_pc_e, 32'h1006);
        cycle();
        issue(0, 1, 0, 3'd0, 1, 32'h600, 32'h100);
        cycle();
        idle();
        cycle();

        // Illegal funct3 with Branch
        issue(1, 0, 0, 3'd2, 0, 32'h700, 32'h8);
        cycle();
        idle();
        src_a_e = 1; src_b_e = 1;
        #1 chk("illegal", {31'd0, illegal_br_e}, 32'd1);
        cycle();
        cycle();

        // Flush with a redirect pending; then flush+stall together
        issue(1, 0, 0, 3'd0, 0, 32'h800, 32'h10);
        cycle();
        issue(0, 1, 0, 3'd0, 0, 32'h900, 32'h10);
        flush_e = 1;
        cycle();
        flush_e = 0;
        cycle();
        cycle();
        idle();
        stall_e = 1; flush_e = 1;
        cycle();
        stall_e = 0; flush_e = 0;
        cycle();

        // Reset mid-stall of a redirecting JALR
        issue(0, 0, 1, 3'd0, 0, 32'hA00, 32'h0);
        cycle();
        idle();
        stall_e = 1;
        cycle();
        reset = 1;
        cycle();
        reset = 0; stall_e = 0;
        cycle();

        // Saturation: stream of mispredicted beqs
        src_a_e = 9; src_b_e = 9;
        for (int i = 0; i < 40; i++) begin
            issue(1, 0, 0, 3'd0, 0, 32'h1000 + 32'(i * 4), 32'h40);
            cycle();
        end
        idle();
        cycle();
        chk("sat_bc", 32'(branch_cnt), CMAX);
        chk("sat_mc", 32'(mispred_cnt), CMAX);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit [2:0] kind;
            reset   = ($urandom_range(63) == 0);
            stall_e = ($urandom_range(5) == 0);
            flush_e = ($urandom_range(9) == 0);
            kind    = 3'($urandom_range(7));
            valid_d = ($urandom_range(4) != 0);
            Branch_d = kind[0]; Jump_d = kind[1]; JumpReg_d = kind[2];
            funct3_d = 3'($urandom_range(7));
            pred_taken_d = 1'($urandom_range(1));
            pc_d  = $urandom() & ~32'd3;
            imm_d = 32'($signed(12'($urandom_range(4095))));
            src_a_e = $urandom();
            src_b_e = ($urandom_range(2) == 0) ? src_a_e :
                      (($urandom_range(1) == 0) ? src_a_e + 32'd1 : $urandom());
            cycle();
        end
        reset = 0; stall_e = 0; flush_e = 0;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
